pso_req_ctrl: RTL and testbench

Requester-side companion to the power-controller state machine. It decides when a module domain enters power shut-off (PSO) and drives L1_module_req to the controller. It consumes the controller's set_status_module and clr_status_module handshake pulses and tracks domain status. It also handles wake-up events and reports handshake errors to the system.

---
 rtl/pso_req_ctrl_if.sv | 19 +
 rtl/pso_req_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pso_req_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pso_req_ctrl_if.sv
// Handshake between the PSO requester and the power controller.
// master = requester (drives L1_module_req), slave = controller (drives the status pulses).
interface pso_req_ctrl_if;
  logic L1_module_req;
  logic set_status_module;
  logic clr_status_module;

  modport master (
    output L1_module_req,
    input  set_status_module,
    input  clr_status_module
  );

  modport slave (
    input  L1_module_req,
    output set_status_module,
    output clr_status_module
  );
endinterface

// File: rtl/pso_req_ctrl.sv
// PSO requester: decides when the domain asks for shut-off, tracks controller status, handles wake-up.
// Optional wake watchdog enabled by defining PSO_WAKE_TIMEOUT_EN.
module pso_req_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MIN_OFF = 8,
  parameter int WAKE_TO = 64
) (
  input  logic             pclk,
  input  logic             nprst,
  pso_req_ctrl_if.master   hs,
  input  logic             module_idle,
  input  logic             wakeup_event,
  input  logic             sw_sleep,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             err_clr,
  output logic             pso_status,
  output logic             wake_pending,
  output logic             wake_done,
  output logic             hs_err
);

  localparam int OFF_W = $clog2(MIN_OFF + 1);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MIN_OFF);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_COUNT,
    ST_REQ,
    ST_DOWN,
    ST_WAKE
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             pso_q, pso_d;
  logic             wp_q, wp_d;
  logic             wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [OFF_W-1:0] off_cnt_q, off_cnt_d;

  logic [CNT_W-1:0] idle_inc;
  logic [OFF_W-1:0] off_inc;
  logic             stray_set;
  logic             stray_clr;
  logic             thresh_one;
  logic             thresh_off;

  assign idle_inc   = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
  assign off_inc    = (off_cnt_q == OFF_MAX) ? OFF_MAX : off_cnt_q + 1'b1;
  assign thresh_one = (idle_thresh == CNT_W'(1));
  assign thresh_off = (idle_thresh == '0);

  // Status pulses are only legal in the state that is waiting for them.
  assign stray_set = hs.set_status_module && (state_q != ST_REQ);
  assign stray_clr = hs.clr_status_module && (state_q != ST_WAKE);

`ifdef PSO_WAKE_TIMEOUT_EN
  localparam int WT_W = $clog2(WAKE_TO + 1);
  logic [WT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic            wake_to_hit;

  assign wake_to_hit = (wake_cnt_q == WT_W'(WAKE_TO - 1));
`else
  logic [31:0] unused_wake_to;
  assign unused_wake_to = WAKE_TO;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    pso_d      = pso_q;
    wp_d       = wp_q;
    wd_d       = 1'b0;
    idle_cnt_d = idle_cnt_q;
    off_cnt_d  = off_cnt_q;
    err_d      = err_q & ~err_clr;
`ifdef PSO_WAKE_TIMEOUT_EN
    wake_cnt_d = wake_cnt_q;
`endif

    if (stray_set || stray_clr) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_ACTIVE: begin
        if (!wakeup_event) begin
          if (sw_sleep) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end else if (module_idle && !thresh_off) begin
            // A threshold of one is already met by this first idle sample.
            if (thresh_one) begin
              state_d = ST_REQ;
              req_d   = 1'b1;
            end else begin
              state_d    = ST_COUNT;
              idle_cnt_d = CNT_W'(1);
            end
          end
        end
      end

      ST_COUNT: begin
        if (!module_idle || wakeup_event || thresh_off) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else if (idle_inc == idle_thresh) begin
          state_d    = ST_REQ;
          req_d      = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end

      ST_REQ: begin
        if (hs.set_status_module) begin
          // A coincident wake cannot abort: the controller has already committed.
          state_d   = ST_DOWN;
          pso_d     = 1'b1;
          off_cnt_d = '0;
          wp_d      = wakeup_event;
        end else if (wakeup_event) begin
          state_d = ST_ACTIVE;
          req_d   = 1'b0;
        end
      end

      ST_DOWN: begin
        if (wp_q && (off_cnt_q == OFF_MAX)) begin
          state_d = ST_WAKE;
          req_d   = 1'b0;
          wp_d    = 1'b0;
`ifdef PSO_WAKE_TIMEOUT_EN
          wake_cnt_d = '0;
`endif
        end else begin
          off_cnt_d = off_inc;
          if (wakeup_event) begin
            wp_d = 1'b1;
          end
        end
      end

      ST_WAKE: begin
        if (hs.clr_status_module) begin
          state_d = ST_ACTIVE;
          pso_d   = 1'b0;
          wd_d    = 1'b1;
        end
`ifdef PSO_WAKE_TIMEOUT_EN
        else if (wake_to_hit) begin
          state_d = ST_ACTIVE;
          pso_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_ACTIVE;
        req_d   = 1'b0;
        pso_d   = 1'b0;
        wp_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge nprst) begin
    if (!nprst) begin
      state_q    <= ST_ACTIVE;
      req_q      <= 1'b0;
      pso_q      <= 1'b0;
      wp_q       <= 1'b0;
      wd_q       <= 1'b0;
      err_q      <= 1'b0;
      idle_cnt_q <= '0;
      off_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pso_q      <= pso_d;
      wp_q       <= wp_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      idle_cnt_q <= idle_cnt_d;
      off_cnt_q  <= off_cnt_d;
    end
  end

`ifdef PSO_WAKE_TIMEOUT_EN
  always_ff @(posedge pclk or negedge nprst) begin
    if (!nprst) begin
      wake_cnt_q <= '0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
    end
  end
`endif

  assign hs.L1_module_req = req_q;
  assign pso_status       = pso_q;
  assign wake_pending     = wp_q;
  assign wake_done        = wd_q;
  assign hs_err           = err_q;

endmodule

// File: tb/tb_pso_req_ctrl.sv
// Self-checking bench for pso_req_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_pso_req_ctrl;
  localparam int CNT_W   = 16;
  localparam int MIN_OFF = 8;
  localparam int WAKE_TO = 64;
  localparam int MAXC    = (1 << CNT_W) - 1;

  localparam int PH_ACT  = 0;
  localparam int PH_CNT  = 1;
  localparam int PH_REQ  = 2;
  localparam int PH_DOWN = 3;
  localparam int PH_WAKE = 4;

  logic             pclk = 1'b0;
  logic             nprst;
  logic             module_idle;
  logic             wakeup_event;
  logic             sw_sleep;
  logic [CNT_W-1:0] idle_thresh;
  logic             err_clr;
  logic             pso_status;
  logic             wake_pending;
  logic             wake_done;
  logic             hs_err;

  pso_req_ctrl_if hs_if ();

  pso_req_ctrl #(.CNT_W(CNT_W), .MIN_OFF(MIN_OFF), .WAKE_TO(WAKE_TO)) dut (
    .pclk         (pclk),
    .nprst        (nprst),
    .hs           (hs_if.master),
    .module_idle  (module_idle),
    .wakeup_event (wakeup_event),
    .sw_sleep     (sw_sleep),
    .idle_thresh  (idle_thresh),
    .err_clr      (err_clr),
    .pso_status   (pso_status),
    .wake_pending (wake_pending),
    .wake_done    (wake_done),
    .hs_err       (hs_err)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus counters, updated from the behavioural rules once per clock.
  int   m_ph;
  int   m_idle, m_off, m_wt;
  logic m_req, m_pso, m_wp, m_wd, m_err;

  function automatic void model_reset();
    m_ph = PH_ACT; m_idle = 0; m_off = 0; m_wt = 0;
    m_req = 0; m_pso = 0; m_wp = 0; m_wd = 0; m_err = 0;
  endfunction

  function automatic void model_step();
    bit e;
    e = (hs_if.set_status_module && m_ph != PH_REQ) || (hs_if.clr_status_module && m_ph != PH_WAKE);
    m_wd = 0;
    case (m_ph)
      PH_ACT: begin
        if (!wakeup_event) begin
          if (sw_sleep) begin
            m_ph = PH_REQ; m_req = 1;
          end else if (module_idle && idle_thresh != 0) begin
            if (idle_thresh == 1) begin m_ph = PH_REQ; m_req = 1; end
            else begin m_ph = PH_CNT; m_idle = 1; end
          end
        end
      end
      PH_CNT: begin
        if (!module_idle || wakeup_event || idle_thresh == 0) begin
          m_ph = PH_ACT; m_idle = 0;
        end else begin
          m_idle = (m_idle == MAXC) ? MAXC : m_idle + 1;
          if (m_idle == int'(idle_thresh)) begin m_ph = PH_REQ; m_req = 1; m_idle = 0; end
        end
      end
      PH_REQ: begin
        if (hs_if.set_status_module) begin
          m_ph = PH_DOWN; m_pso = 1; m_off = 0; m_wp = wakeup_event;
        end else if (wakeup_event) begin
          m_ph = PH_ACT; m_req = 0;
        end
      end
      PH_DOWN: begin
        if (m_wp && m_off == MIN_OFF) begin
          m_ph = PH_WAKE; m_req = 0; m_wp = 0; m_wt = 0;
        end else begin
          m_off = (m_off >= MIN_OFF) ? MIN_OFF : m_off + 1;
          if (wakeup_event) m_wp = 1;
        end
      end
      PH_WAKE: begin
        if (hs_if.clr_status_module) begin
          m_ph = PH_ACT; m_pso = 0; m_wd = 1;
        end
`ifdef PSO_WAKE_TIMEOUT_EN
        else if (m_wt + 1 == WAKE_TO) begin
          m_ph = PH_ACT; m_pso = 0; e = 1;
        end else begin
          m_wt = m_wt + 1;
        end
`endif
      end
      default: m_ph = PH_ACT;
    endcase
    m_err = (m_err && !err_clr) || e;
  endfunction

  function automatic logic [4:0] obs();
    return {hs_if.L1_module_req, pso_status, wake_pending, wake_done, hs_err};
  endfunction

  function automatic logic [4:0] mdl();
    return {m_req, m_pso, m_wp, m_wd, m_err};
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1 time unit past it.
  task automatic cyc(input logic idle, input logic wk, input logic sw,
                     input logic st, input logic cl, input logic ec);
    module_idle = idle; wakeup_event = wk; sw_sleep = sw;
    hs_if.set_status_module = st; hs_if.clr_status_module = cl; err_clr = ec;
    @(posedge pclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    nprst = 1'b0;
    module_idle = 0; wakeup_event = 0; sw_sleep = 0; err_clr = 0;
    hs_if.set_status_module = 0; hs_if.clr_status_module = 0;
    model_reset();
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    nprst = 1'b1;
  endtask

  task automatic test_reset();
    idle_thresh = 4;
    do_reset();
    total++; if (hs_if.L1_module_req !== 1'b0) begin bad++; $display("FAIL rst_req: got=%b want=0", hs_if.L1_module_req); end
    total++; if (pso_status !== 1'b0) begin bad++; $display("FAIL rst_pso: got=%b want=0", pso_status); end
    total++; if (wake_pending !== 1'b0) begin bad++; $display("FAIL rst_wp: got=%b want=0", wake_pending); end
    total++; if (wake_done !== 1'b0) begin bad++; $display("FAIL rst_wd: got=%b want=0", wake_done); end
    total++; if (hs_err !== 1'b0) begin bad++; $display("FAIL rst_err: got=%b want=0", hs_err); end
    $display("test_reset: outputs=%b", obs());
  endtask

  task automatic test_idle_request();
    idle_thresh = 4;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      total++;
      if (obs() !== ((i == 4) ? 5'b10000 : 5'b00000)) begin
        bad++; $display("FAIL idle4_cycle%0d: got=%b want=%b", i, obs(), (i == 4) ? 5'b10000 : 5'b00000);
      end
    end
    cyc(0, 0, 0, 1, 0, 0);
    total++; if (obs() !== 5'b11000) begin bad++; $display("FAIL idle4_set: got=%b want=11000", obs()); end
    cyc(0, 1, 0, 0, 0, 0);
    total++; if (obs() !== 5'b11100) begin bad++; $display("FAIL idle4_wake: got=%b want=11100", obs()); end
    for (int i = 0; i < 20 && hs_if.L1_module_req; i++) cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b01000) begin bad++; $display("FAIL idle4_drop: got=%b want=01000", obs()); end
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (obs() !== 5'b00010) begin bad++; $display("FAIL idle4_clr: got=%b want=00010", obs()); end
    $display("test_idle_request: final=%b", obs());
  endtask

  task automatic test_idle_abort();
    idle_thresh = 4;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL abort_break: got=%b want=00000", obs()); end
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL abort_recount3: got=%b want=00000", obs()); end
    cyc(1, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL abort_recount4: got=%b want=10000", obs()); end
    cyc(1, 1, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL abort_req_wake: got=%b want=00000", obs()); end
    $display("test_idle_abort: final=%b", obs());
  endtask

  task automatic test_thresh_bounds();
    idle_thresh = 1;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL thr1_req: got=%b want=10000", obs()); end
    cyc(0, 1, 0, 0, 0, 0);
    idle_thresh = 0;
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL thr0_noreq: got=%b want=00000", obs()); end
    cyc(1, 1, 1, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL sw_blocked: got=%b want=00000", obs()); end
    cyc(0, 0, 1, 0, 0, 0);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL sw_req: got=%b want=10000", obs()); end
    $display("test_thresh_bounds: final=%b", obs());
  endtask

  task automatic test_wake_in_down();
    idle_thresh = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    total++; if (obs() !== 5'b11100) begin bad++; $display("FAIL down_wp: got=%b want=11100", obs()); end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b11100) begin bad++; $display("FAIL down_hold: got=%b want=11100", obs()); end
    cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b01000) begin bad++; $display("FAIL down_release: got=%b want=01000", obs()); end
    cyc(0, 1, 0, 0, 0, 0);
    total++; if (obs() !== 5'b01000) begin bad++; $display("FAIL wake_ignored: got=%b want=01000", obs()); end
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (obs() !== 5'b00010) begin bad++; $display("FAIL wake_done: got=%b want=00010", obs()); end
    cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL wake_done_pulse: got=%b want=00000", obs()); end
    $display("test_wake_in_down: final=%b", obs());
  endtask

  task automatic test_wake_coincident();
    idle_thresh = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    total++; if (obs() !== 5'b11100) begin bad++; $display("FAIL coinc_down: got=%b want=11100", obs()); end
    for (int i = 0; i < MIN_OFF; i++) cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b11100) begin bad++; $display("FAIL coinc_hold: got=%b want=11100", obs()); end
    cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b01000) begin bad++; $display("FAIL coinc_release: got=%b want=01000", obs()); end
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (obs() !== 5'b00010) begin bad++; $display("FAIL coinc_clr: got=%b want=00010", obs()); end
    $display("test_wake_coincident: final=%b", obs());
  endtask

  task automatic test_errors();
    idle_thresh = 0;
    do_reset();
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (obs() !== 5'b00001) begin bad++; $display("FAIL err_clr_active: got=%b want=00001", obs()); end
    cyc(0, 0, 0, 0, 0, 1);
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL err_cleared: got=%b want=00000", obs()); end
    cyc(0, 0, 0, 1, 0, 0);
    total++; if (obs() !== 5'b00001) begin bad++; $display("FAIL err_set_active: got=%b want=00001", obs()); end
    cyc(0, 0, 0, 1, 0, 1);
    total++; if (obs() !== 5'b00001) begin bad++; $display("FAIL err_wins: got=%b want=00001", obs()); end
    cyc(0, 0, 1, 0, 0, 1);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL err_still_active: got=%b want=10000", obs()); end
    cyc(0, 0, 0, 0, 1, 0);
    total++; if (obs() !== 5'b10001) begin bad++; $display("FAIL err_clr_req: got=%b want=10001", obs()); end
    cyc(0, 0, 0, 1, 0, 1);
    total++; if (obs() !== 5'b11000) begin bad++; $display("FAIL err_req_set: got=%b want=11000", obs()); end
    cyc(0, 0, 0, 1, 0, 0);
    total++; if (obs() !== 5'b11001) begin bad++; $display("FAIL err_set_down: got=%b want=11001", obs()); end
    $display("test_errors: final=%b", obs());
  endtask

  task automatic test_async_reset();
    idle_thresh = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    #2 nprst = 1'b0;
    #1;
    model_reset();
    total++; if (obs() !== 5'b00000) begin bad++; $display("FAIL async_rst: got=%b want=00000", obs()); end
    @(posedge pclk); #1;
    nprst = 1'b1;
    cyc(0, 0, 1, 0, 0, 0);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL async_rst_active: got=%b want=10000", obs()); end
    $display("test_async_reset: final=%b", obs());
  endtask

`ifdef PSO_WAKE_TIMEOUT_EN
  task automatic test_wake_timeout();
    idle_thresh = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 20 && hs_if.L1_module_req; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WAKE_TO - 1; i++) cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b01000) begin bad++; $display("FAIL to_before: got=%b want=01000", obs()); end
    cyc(0, 0, 0, 0, 0, 0);
    total++; if (obs() !== 5'b00001) begin bad++; $display("FAIL to_fire: got=%b want=00001", obs()); end
    cyc(0, 0, 1, 0, 0, 1);
    total++; if (obs() !== 5'b10000) begin bad++; $display("FAIL to_active: got=%b want=10000", obs()); end
    $display("test_wake_timeout: final=%b", obs());
  endtask
`endif

  task automatic test_random();
    int shown;
    int cyc_bad;
    logic st, cl;
    shown = 0;
    for (int run = 0; run < 6; run++) begin
      idle_thresh = CNT_W'($urandom_range(0, 6));
      do_reset();
      cyc_bad = 0;
      for (int n = 0; n < 500; n++) begin
        st = hs_if.L1_module_req && !pso_status && ($urandom_range(0, 2) == 0);
        cl = pso_status && !hs_if.L1_module_req && ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 79) == 0) st = 1'b1;
        if ($urandom_range(0, 79) == 0) cl = 1'b1;
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
            st, cl, $urandom_range(0, 9) == 0);
        total++;
        if (obs() !== mdl()) begin
          bad++; cyc_bad++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random_run%0d_cycle%0d: got=%b want=%b", run, n, obs(), mdl());
          end
        end
      end
      $display("test_random run %0d: thresh=%0d mismatching_cycles=%0d", run, idle_thresh, cyc_bad);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hs_if.set_status_module = 0;
    hs_if.clr_status_module = 0;
    idle_thresh = 0;
    test_reset();
    test_idle_request();
    test_idle_abort();
    test_thresh_bounds();
    test_wake_in_down();
    test_wake_coincident();
    test_errors();
    test_async_reset();
`ifdef PSO_WAKE_TIMEOUT_EN
    test_wake_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
